// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder built from one full-adder cell and a carry
// flip-flop. Two WIDTH-bit operands are added LSB-first, one bit per clock,
// behind a start/busy/done handshake. sum/cout hold the last completed result.
//
// Optional feature macro: SERIAL_ADDER_SUB_EN
//   When defined, a 'sub' input is added and captured with the operands;
//   sub=1 computes a-b (two's complement: ~b with carry-in forced to 1), and
//   cout=1 then means "no borrow". When undefined the block only adds.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] acc_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic             sub_w;
  logic [WIDTH-1:0] b_load_d;
  logic             c_load_d;
  logic             sum_bit_d;
  logic             carry_d;
  logic [WIDTH-1:0] acc_d;
  logic             last_bit_d;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_w = sub;
`else
  assign sub_w = 1'b0;
`endif

  // Full-adder cell on the current LSBs, operand-load selection and last-bit detect.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign every output on every path, so no latch is inferred.
    b_load_d   = sub_w ? ~b : b;
    c_load_d   = sub_w ? 1'b1 : cin;
    sum_bit_d  = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    carry_d    = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));
    acc_d      = {sum_bit_d, acc_q[WIDTH-1:1]};
    last_bit_d = (cnt_q == CW'(WIDTH - 1));
  end

  // Control FSM and datapath registers; all outputs come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b_load_d;
            carry_q <= c_load_d;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_sh_q  <= {1'b0, a_sh_q[WIDTH-1:1]};
          b_sh_q  <= {1'b0, b_sh_q[WIDTH-1:1]};
          acc_q   <= acc_d;
          carry_q <= carry_d;
          cnt_q   <= cnt_q + CW'(1);
          if (last_bit_d) begin
            sum_q   <= acc_d;
            cout_q  <= carry_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: an 8-bit instance checked every cycle
// against a timing/arithmetic model, plus 2-bit and 32-bit instances exercised
// with random operands.
module tb_serial_adder;

  localparam int W8 = 8;

  logic clk;
  logic rst_n;

  logic        start8, cin8, sub8, busy8, done8, cout8;
  logic [7:0]  a8, b8, sum8;
  logic        start2, cin2, busy2, done2, cout2;
  logic [1:0]  a2, b2, sum2;
  logic        start32, cin32, busy32, done32, cout32;
  logic [31:0] a32, b32, sum32;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub8),
`endif
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(1'b0),
`endif
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
  );

  serial_adder #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .a(a32), .b(b32), .cin(cin32),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(1'b0),
`endif
    .busy(busy32), .done(done32), .sum(sum32), .cout(cout32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model for the 8-bit instance: 'age' = clock edges since the
  // accepted start (-1 when no operation is in flight). The result is the
  // plain integer sum of the operands captured at the accept.
  int         age;
  logic [8:0] pend;
  logic [8:0] exp_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age     = -1;
      pend    = '0;
      exp_res = '0;
    end else if (age < 0) begin
      if (start8) begin
        age  = 0;
        pend = sub8 ? ({1'b0, a8} + {1'b0, ~b8} + 9'd1)
                    : ({1'b0, a8} + {1'b0, b8} + {8'd0, cin8});
      end
    end else if (age == W8) begin
      age = -1;
    end else begin
      age++;
      if (age == W8) exp_res = pend;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    check("busy8", busy8, (age >= 0 && age < W8));
    check("done8", done8, (age == W8));
    check("sum8",  sum8,  exp_res[7:0]);
    check("cout8", cout8, exp_res[8]);
  end

  task automatic op8(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                     input logic ts, output int lat);
    int t_acc;
    int k;
    @(negedge clk);
    a8 = ta; b8 = tb_v; cin8 = tc; sub8 = ts; start8 = 1'b1;
    t_acc = cyc + 1;
    @(negedge clk);
    start8 = 1'b0;
    k = 0;
    while (!done8 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("op8_done_seen", done8, 1'b1);
    lat = cyc - t_acc;
  endtask

  task automatic wait_done8(output int t);
    int k;
    k = 0;
    @(negedge clk);
    while (!done8 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("wait8_done_seen", done8, 1'b1);
    t = cyc;
  endtask

  task automatic run_w2(input int n);
    logic [2:0] exp_v;
    logic [2:0] prev;
    int k;
    prev = {cout2, sum2};
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      a2 = 2'($urandom); b2 = 2'($urandom); cin2 = 1'($urandom); start2 = 1'b1;
      exp_v = {1'b0, a2} + {1'b0, b2} + {2'd0, cin2};
      @(negedge clk);
      start2 = 1'b0;
      check("w2_hold", {cout2, sum2}, prev);
      k = 0;
      while (!done2 && k < 20) begin
        @(negedge clk);
        k++;
      end
      check("w2_done_seen", done2, 1'b1);
      check("w2_result", {cout2, sum2}, exp_v);
      @(negedge clk);
      check("w2_pulse_width", done2, 1'b0);
      prev = exp_v;
    end
  endtask

  task automatic run_w32(input int n);
    logic [32:0] exp_v;
    logic [32:0] prev;
    int k;
    prev = {cout32, sum32};
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom); start32 = 1'b1;
      exp_v = {1'b0, a32} + {1'b0, b32} + {32'd0, cin32};
      @(negedge clk);
      start32 = 1'b0;
      check("w32_hold", {cout32, sum32}, prev);
      k = 0;
      while (!done32 && k < 50) begin
        @(negedge clk);
        k++;
      end
      check("w32_done_seen", done32, 1'b1);
      check("w32_result", {cout32, sum32}, exp_v);
      @(negedge clk);
      check("w32_pulse_width", done32, 1'b0);
      prev = exp_v;
    end
  endtask

  initial begin
    int lat;
    int t1;
    int t2;
    int nbusy;
    int ndone;
    rst_n = 1'b0;
    start8 = 0; a8 = '0; b8 = '0; cin8 = 0; sub8 = 0;
    start2 = 0; a2 = '0; b2 = '0; cin2 = 0;
    start32 = 0; a32 = '0; b32 = '0; cin32 = 0;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", busy8, 1'b0);
    check("rst_done", done8, 1'b0);
    check("rst_sum",  sum8, 8'h00);
    check("rst_cout", cout8, 1'b0);
    rst_n = 1'b1;

    // Directed vectors with hand-computed results.
    op8(8'h00, 8'h00, 1'b0, 1'b0, lat);
    check("lat_00", lat, 8);
    check("sum_00", sum8, 8'h00);
    check("cout_00", cout8, 1'b0);
    op8(8'h35, 8'h4A, 1'b1, 1'b0, lat);
    check("sum_35_4A", sum8, 8'h80);
    check("cout_35_4A", cout8, 1'b0);
    op8(8'hFF, 8'h01, 1'b0, 1'b0, lat);
    check("sum_FF_01", sum8, 8'h00);
    check("cout_FF_01", cout8, 1'b1);
    op8(8'hFF, 8'hFF, 1'b1, 1'b0, lat);
    check("sum_FF_FF", sum8, 8'hFF);
    check("cout_FF_FF", cout8, 1'b1);

    // Reset during the third bit aborts the operation.
    @(negedge clk);
    @(negedge clk);
    a8 = 8'h35; b8 = 8'h4A; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", busy8, 1'b0);
    check("abort_done", done8, 1'b0);
    check("abort_sum",  sum8, 8'h00);
    check("abort_cout", cout8, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    check("abort_no_done", ndone, 0);
    op8(8'h35, 8'h4A, 1'b1, 1'b0, lat);
    check("after_abort_lat", lat, 8);
    check("after_abort_sum", sum8, 8'h80);

`ifdef SERIAL_ADDER_SUB_EN
    op8(8'h10, 8'h01, 1'b0, 1'b1, lat);
    check("sub_10_01_sum", sum8, 8'h0F);
    check("sub_10_01_cout", cout8, 1'b1);
    op8(8'h01, 8'h02, 1'b1, 1'b1, lat);
    check("sub_01_02_sum", sum8, 8'hFF);
    check("sub_01_02_cout", cout8, 1'b0);
    sub8 = 1'b0;
`endif

    // start held high: accepts every WIDTH+2 cycles, operands captured at accept.
    @(negedge clk);
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    a8 = 8'hAA; b8 = 8'h55;
    wait_done8(t1);
    check("held_sum1", sum8, 8'h46);
    check("held_cout1", cout8, 1'b0);
    nbusy = 0;
    for (int i = 0; i < 40 && !(done8 && cyc != t1); i++) begin
      @(negedge clk);
      if (busy8) nbusy++;
    end
    t2 = cyc;
    check("held_done2", done8, 1'b1);
    check("held_period", t2 - t1, 10);
    check("held_busy_cycles", nbusy, 8);
    check("held_sum2", sum8, 8'hFF);
    check("held_cout2", cout8, 1'b0);
    start8 = 1'b0;

    // Random traffic on the 8-bit instance; the compare process checks it.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start8 = 1'($urandom);
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      sub8 = 1'($urandom);
`endif
    end
    start8 = 1'b0;
    for (int i = 0; i < 12; i++) @(negedge clk);

    run_w2(1000);
    run_w32(1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
